// File: rtl/axi_sdram_pkg.sv
// axi_sdram_pkg: shared constants and helpers for the AXI-SDRAM W/B channel
package axi_sdram_pkg;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic logic [15:0] first_beat_keep_mask(input int addr_lsb, input int strb_width);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) m[i] = (i >= addr_lsb) && (i < strb_width);
      return m;
   endfunction
endpackage

// File: rtl/axi_sdram_bresp_queue.sv
// axi_sdram_bresp_queue: sync FIFO of pending B responses; WIDTH 0 keeps only an occupancy count
module axi_sdram_bresp_queue
   import axi_sdram_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int DW = (WIDTH > 0) ? WIDTH : 1,
   parameter int AW = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic wr, rd;
   assign rd = pop & ~empty;
   assign wr = push & (~full | rd);
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   // Occupancy: a simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) level <= '0;
      else if (wr != rd) level <= wr ? level + 1'b1 : level - 1'b1;
   generate
      if (WIDTH == 0) begin : g_cnt
         logic unused_din;
         assign unused_din = ^din;
         assign dout = '0;
      end else begin : g_mem
         logic [DW-1:0] mem [DEPTH];
         logic [AW-1:0] wp, rp;
         assign dout = mem[rp];
         // Read/write pointers wrap on their own since the depth is a power of two
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               wp <= '0;
               rp <= '0;
            end else begin
               if (wr) wp <= wp + 1'b1;
               if (rd) rp <= rp + 1'b1;
            end
         // Storage is never reset; only entries below the level are ever read
         always_ff @(posedge clk)
            if (wr) mem[wp] <= din;
      end
   endgenerate
endmodule

// File: rtl/axi_sdram_w_b_chn_mo.sv
// axi_sdram_w_b_chn_mo: AXI W/B front end; realigns first W beat, forwards to SDRAM AXIS, queues B responses
// Define AXI_SDRAM_WB_BID_EN to store the burst ID and return it on BID; otherwise BID is 0
module axi_sdram_w_b_chn_mo
   import axi_sdram_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int ADDR_LSB_W    = clog2(STRB_WIDTH),
   parameter int ID_WIDTH      = 4,
   parameter int B_QUEUE_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]          s_axi_wstrb,
   input  logic                           s_axi_wlast,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [ID_WIDTH-1:0]            s_axi_bid,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   output logic [DATA_WIDTH-1:0]          m_axis_wt_data,
   output logic [STRB_WIDTH-1:0]          m_axis_wt_keep,
   output logic                           m_axis_wt_last,
   output logic                           m_axis_wt_valid,
   input  logic                           m_axis_wt_ready,
   output logic                           wt_burst_msg_fifo_ren,
   input  logic [ID_WIDTH+ADDR_LSB_W-1:0] wt_burst_msg_fifo_dout,
   input  logic                           wt_burst_msg_fifo_empty_n,
   output logic [clog2(B_QUEUE_DEPTH):0]  b_queue_level
);
`ifdef AXI_SDRAM_WB_BID_EN
   localparam int QW = ID_WIDTH;
`else
   localparam int QW = 0;
`endif
   localparam int QD = (QW > 0) ? QW : 1;
   logic first_beat, go, w_hs, bq_full, bq_empty;
   logic [ADDR_LSB_W-1:0] addr_lsb;
   logic [ID_WIDTH-1:0] msg_id;
   logic [STRB_WIDTH-1:0] mask;
   logic [QD-1:0] bq_din, bq_dout;
   assign {msg_id, addr_lsb} = wt_burst_msg_fifo_dout;
   assign go = wt_burst_msg_fifo_empty_n & ~bq_full;
   assign s_axi_wready = go & m_axis_wt_ready;
   assign m_axis_wt_valid = go & s_axi_wvalid;
   assign w_hs = s_axi_wvalid & s_axi_wready;
   assign wt_burst_msg_fifo_ren = w_hs & s_axi_wlast;
   assign mask = STRB_WIDTH'(first_beat_keep_mask(int'(addr_lsb), STRB_WIDTH));
   assign m_axis_wt_keep = first_beat ? s_axi_wstrb & mask : s_axi_wstrb;
   assign m_axis_wt_data = s_axi_wdata;
   assign m_axis_wt_last = s_axi_wlast;
   assign s_axi_bresp = AXI_RESP_OKAY;
   assign s_axi_bvalid = ~bq_empty;
`ifdef AXI_SDRAM_WB_BID_EN
   assign bq_din = msg_id;
   assign s_axi_bid = bq_empty ? '0 : bq_dout;
`else
   logic unused_id;
   assign unused_id = ^{msg_id, bq_dout};
   assign bq_din = 1'b0;
   assign s_axi_bid = '0;
`endif
   // Marks whether the next W beat opens a burst; a last beat re-arms it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) first_beat <= 1'b1;
      else if (w_hs) first_beat <= s_axi_wlast;
   axi_sdram_bresp_queue #(.WIDTH(QW), .DEPTH(B_QUEUE_DEPTH)) u_bq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wt_burst_msg_fifo_ren),
      .pop   (s_axi_bvalid & s_axi_bready),
      .din   (bq_din),
      .dout  (bq_dout),
      .full  (bq_full),
      .empty (bq_empty),
      .level (b_queue_level)
   );
endmodule

// File: tb/tb_axi_sdram_w_b_chn_mo.sv
// tb_axi_sdram_w_b_chn_mo: scoreboard bench for the W/B channel front end
module tb_axi_sdram_w_b_chn_mo;
   localparam int DW = 32, SW = DW / 8, AL = 2, IW = 4, DEPTH = 4, LW = 3;
`ifdef AXI_SDRAM_WB_BID_EN
   localparam bit BID_EN = 1'b1;
`else
   localparam bit BID_EN = 1'b0;
`endif
   logic clk = 0, rst_n = 0;
   logic [DW-1:0] s_axi_wdata = '0, m_axis_wt_data;
   logic [SW-1:0] s_axi_wstrb = '0, m_axis_wt_keep;
   logic s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready, s_axi_bvalid, s_axi_bready = 0;
   logic [IW-1:0] s_axi_bid;
   logic [1:0] s_axi_bresp;
   logic m_axis_wt_last, m_axis_wt_valid, m_axis_wt_ready = 1, wt_burst_msg_fifo_ren;
   logic [IW+AL-1:0] wt_burst_msg_fifo_dout = '0;
   logic wt_burst_msg_fifo_empty_n = 0;
   logic [LW-1:0] b_queue_level;
   int n_cmp = 0, n_err = 0, cnt = 0;
   logic [IW+AL-1:0] msgq[$];
   logic [DW+SW:0] exp_w[$];
   logic [IW-1:0] exp_b[$];
   logic rnd = 0, acc = 0;
   logic bv_p = 0, br_p = 0, go_e, whs, bhs;
   logic [IW-1:0] bid_p = '0, eb;
   logic [DW+SW:0] ew;

   axi_sdram_w_b_chn_mo #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .B_QUEUE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .m_axis_wt_data(m_axis_wt_data), .m_axis_wt_keep(m_axis_wt_keep),
      .m_axis_wt_last(m_axis_wt_last), .m_axis_wt_valid(m_axis_wt_valid),
      .m_axis_wt_ready(m_axis_wt_ready),
      .wt_burst_msg_fifo_ren(wt_burst_msg_fifo_ren), .wt_burst_msg_fifo_dout(wt_burst_msg_fifo_dout),
      .wt_burst_msg_fifo_empty_n(wt_burst_msg_fifo_empty_n), .b_queue_level(b_queue_level)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", n, a, e);
      end
   endfunction

   // Monitor: checks the handshake rules and pops the scoreboards on every accepted beat/response
   always @(negedge clk) begin
      if (!rst_n) begin
         cnt = 0;
         bv_p = 0;
         br_p = 0;
      end else begin
         go_e = wt_burst_msg_fifo_empty_n && (cnt < DEPTH);
         chk("wready", 64'(s_axi_wready), 64'(go_e && m_axis_wt_ready));
         chk("wt_valid", 64'(m_axis_wt_valid), 64'(go_e && s_axi_wvalid));
         chk("level", 64'(b_queue_level), 64'(cnt));
         chk("bvalid", 64'(s_axi_bvalid), 64'(cnt != 0));
         whs = s_axi_wvalid && s_axi_wready;
         bhs = s_axi_bvalid && s_axi_bready;
         chk("msg_ren", 64'(wt_burst_msg_fifo_ren), 64'(whs && s_axi_wlast));
         if (whs) begin
            if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
            else begin
               ew = exp_w.pop_front();
               chk("wt_data", 64'(m_axis_wt_data), 64'(ew[DW+SW:SW+1]));
               chk("wt_keep", 64'(m_axis_wt_keep), 64'(ew[SW:1]));
               chk("wt_last", 64'(m_axis_wt_last), 64'(ew[0]));
            end
         end
         if (s_axi_bvalid) begin
            chk("bresp", 64'(s_axi_bresp), 64'd0);
            if (bv_p && !br_p) chk("bid_hold", 64'(s_axi_bid), 64'(bid_p));
         end
         if (bhs) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else begin
               eb = exp_b.pop_front();
               chk("bid", 64'(s_axi_bid), BID_EN ? 64'(eb) : 64'd0);
            end
         end
         cnt = cnt + int'(whs && s_axi_wlast) - int'(bhs);
         bv_p = s_axi_bvalid;
         br_p = s_axi_bready;
         bid_p = s_axi_bid;
      end
   end

   task automatic upd_msg();
      wt_burst_msg_fifo_empty_n = msgq.size() > 0;
      wt_burst_msg_fifo_dout = (msgq.size() > 0) ? msgq[0] : '0;
   endtask

   task automatic step();
      logic a, r;
      @(negedge clk);
      a = s_axi_wvalid & s_axi_wready;
      r = wt_burst_msg_fifo_ren;
      @(posedge clk);
      #1;
      if (r && msgq.size() > 0) void'(msgq.pop_front());
      acc = a;
      if (rnd) begin
         m_axis_wt_ready = $urandom_range(0, 3) != 0;
         s_axi_bready = $urandom_range(0, 1) == 1;
      end
      upd_msg();
   endtask

   task automatic beat(input logic [AL-1:0] lsb, input logic first, input logic last, input logic rs);
      logic [SW-1:0] st, ones;
      logic [DW-1:0] d;
      int t;
      ones = '1;
      d = $urandom;
      st = rs ? SW'($urandom) : ones;
      exp_w.push_back({d, first ? (st & (ones << lsb)) : st, last});
      s_axi_wdata = d;
      s_axi_wstrb = st;
      s_axi_wlast = last;
      s_axi_wvalid = 1;
      t = 0;
      do begin
         step();
         t++;
      end while (!acc && t < 300);
      if (!acc) chk("w_timeout", 64'd0, 64'd1);
      s_axi_wvalid = 0;
      if (rnd && $urandom_range(0, 3) == 0) step();
   endtask

   task automatic send_burst(input logic [IW-1:0] id, input logic [AL-1:0] lsb, input int len, input logic rs);
      msgq.push_back({id, lsb});
      exp_b.push_back(id);
      upd_msg();
      for (int b = 0; b < len; b++) beat(lsb, b == 0, b == len - 1, rs);
   endtask

   task automatic drain();
      int t;
      t = 0;
      s_axi_bready = 1;
      while (b_queue_level != 0 && t < 100) begin
         step();
         t++;
      end
      chk("drain_empty", 64'(exp_b.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SW-1:0] ones;
      ones = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
      chk("rst_level", 64'(b_queue_level), 64'd0);
      chk("rst_bid", 64'(s_axi_bid), 64'd0);
      chk("rst_wready", 64'(s_axi_wready), 64'd0);
      rst_n = 1;
      // 4-beat burst offset 2, full strobes: keep C,F,F,F
      send_burst(4'd3, 2'd2, 4, 0);
      chk("b_after_last", 64'(s_axi_bvalid), 64'd1);
      send_burst(4'd5, 2'd3, 1, 0);
      send_burst(4'd6, 2'd1, 2, 0);
      drain();
      // Message FIFO empty stalls W completely
      s_axi_wdata = 32'hA5A5_0001;
      s_axi_wstrb = '1;
      s_axi_wlast = 1;
      s_axi_wvalid = 1;
      exp_w.push_back({32'hA5A5_0001, 4'hE, 1'b1});
      repeat (10) begin
         step();
         chk("stall_acc", 64'(acc), 64'd0);
      end
      msgq.push_back({4'h9, 2'd1});
      exp_b.push_back(4'h9);
      upd_msg();
      #1;
      chk("unstall_wready", 64'(s_axi_wready), 64'd1);
      chk("unstall_valid", 64'(m_axis_wt_valid), 64'd1);
      step();
      chk("unstall_acc", 64'(acc), 64'd1);
      s_axi_wvalid = 0;
      drain();
      // Fill the response queue with bready low; the fifth burst waits for a slot
      s_axi_bready = 0;
      for (int i = 0; i < 4; i++) send_burst(IW'(i + 1), AL'(i), 1, 1);
      msgq.push_back({4'hD, 2'd2});
      exp_b.push_back(4'hD);
      upd_msg();
      s_axi_wdata = 32'h1234_5678;
      s_axi_wstrb = 4'hB;
      s_axi_wlast = 1;
      s_axi_wvalid = 1;
      exp_w.push_back({32'h1234_5678, 4'h8, 1'b1});
      repeat (3) begin
         step();
         chk("full_acc", 64'(acc), 64'd0);
      end
      chk("full_level", 64'(b_queue_level), 64'd4);
      chk("full_wready", 64'(s_axi_wready), 64'd0);
      s_axi_bready = 1;
      step();
      s_axi_bready = 0;
      chk("pulse_acc", 64'(acc), 64'd0);
      step();
      chk("fifth_acc", 64'(acc), 64'd1);
      s_axi_wvalid = 0;
      drain();
      // Reset in the middle of a burst with a response pending
      s_axi_bready = 0;
      send_burst(4'd2, 2'd0, 1, 1);
      chk("pre_rst_bvalid", 64'(s_axi_bvalid), 64'd1);
      msgq.push_back({4'hB, 2'd1});
      upd_msg();
      beat(2'd1, 1, 0, 1);
      beat(2'd1, 0, 0, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_bvalid", 64'(s_axi_bvalid), 64'd0);
      chk("mid_rst_level", 64'(b_queue_level), 64'd0);
      chk("mid_rst_w_empty", 64'(exp_w.size()), 64'd0);
      exp_b.delete();
      msgq.delete();
      upd_msg();
      @(posedge clk);
      #1;
      rst_n = 1;
      send_burst(4'hC, 2'd3, 2, 0);
      drain();
      // Randomized traffic with random AXIS and B backpressure
      rnd = 1;
      for (int i = 0; i < 60; i++) send_burst(IW'($urandom), AL'($urandom), $urandom_range(1, 4), 1);
      rnd = 0;
      m_axis_wt_ready = 1;
      drain();
      chk("end_w_empty", 64'(exp_w.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_sdram_w_b_chn_mo.md
Name: axi_sdram_w_b_chn_mo

Overview:
- Parametrised AXI W/B channel front end for the AXI-SDRAM controller.
- Realigns the first beat of each write burst by clearing byte lanes below the burst start address, then forwards W beats to the SDRAM write-data AXIS.
- Returns one B response per burst through an internal response queue, so further bursts proceed while earlier responses wait for bready (multiple outstanding bursts).

Parameters:
- DATA_WIDTH, 32, W/AXIS data width in bits; one of 32, 64, 128.
- STRB_WIDTH, DATA_WIDTH/8, byte-lane count; derived, never overridden.
- ADDR_LSB_W, log2(STRB_WIDTH), width of the low-address field in the burst message.
- ID_WIDTH, 4, AXI ID width carried in the message and returned on BID.
- B_QUEUE_DEPTH, 4, outstanding-response queue entries; power of two, 2..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  STRB_WIDTH  write strobes
- s_axi_wlast  in  1  last beat of burst
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  ID_WIDTH  response ID (all 0 when the optional feature is off)
- s_axi_bresp  out  2  constant 2'b00 (OKAY)
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- m_axis_wt_data  out  DATA_WIDTH  equals s_axi_wdata
- m_axis_wt_keep  out  STRB_WIDTH  realigned strobes
- m_axis_wt_last  out  1  equals s_axi_wlast
- m_axis_wt_valid  out  1  AXIS valid
- m_axis_wt_ready  in  1  AXIS ready
- wt_burst_msg_fifo_ren  out  1  message FIFO pop
- wt_burst_msg_fifo_dout  in  ID_WIDTH+ADDR_LSB_W  message word: {awid, awaddr[ADDR_LSB_W-1:0]}
- wt_burst_msg_fifo_empty_n  in  1  message FIFO not empty
- b_queue_level  out  log2(B_QUEUE_DEPTH)+1  current number of queued responses

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous, active-low, on rst_n.
- Reset values:
  - first_beat=1, B queue empty.
  - s_axi_bvalid=0, b_queue_level=0, s_axi_bid=0.
  - Combinational outputs follow their inputs from the first cycle after reset.
- Pass condition: go = wt_burst_msg_fifo_empty_n & ~bq_full.
  - s_axi_wready = go & m_axis_wt_ready.
  - m_axis_wt_valid = go & s_axi_wvalid.
  - m_axis_wt_valid must not depend on m_axis_wt_ready.
- Beat handshake: w_hs = s_axi_wvalid & s_axi_wready.
- Keep mask:
  - mask[i] = (i >= addr_lsb), where addr_lsb = low ADDR_LSB_W bits of the message word.
  - keep = first_beat ? (wstrb & mask) : wstrb.
  - A single-beat burst is realigned on that beat.
- first_beat register:
  - Clears on a w_hs without wlast.
  - Sets on a w_hs with wlast.
  - A w_hs with wlast on a first beat leaves it at 1.
- End of burst: on w_hs & wlast, in the same cycle:
  - wt_burst_msg_fifo_ren=1 (pop one message).
  - Push the message ID into the B queue.
  - The realign mask stays valid for that beat because the pop takes effect after the edge.
- B queue:
  - Synchronous FIFO with depth B_QUEUE_DEPTH.
  - s_axi_bvalid = ~bq_empty; s_axi_bid = head entry.
  - Pop on s_axi_bvalid & s_axi_bready.
  - Push and pop in the same cycle: level unchanged; allowed when full, because the pop frees a slot.
  - bq_full stalls W, and the stall includes the case where a pop occurs in the same cycle, which keeps the timing path short.
- Response timing:
  - bvalid rises the cycle after the last-beat handshake (1-cycle latency).
  - bvalid holds with its ID stable until bready.
- Message FIFO empty: W and AXIS are fully stalled; no beat passes without a message.
- Reset mid-burst: first_beat returns to 1 and the queue empties. The upstream logic is reset together with this block, so no cleanup is required.

Optional Feature:
- Macro: AXI_SDRAM_WB_BID_EN.
- Defined: the message ID field is stored in the queue and driven on s_axi_bid.
- Undefined:
  - The ID field is ignored; queue entries carry no data and are reduced to an occupancy counter.
  - s_axi_bid is tied to 0.
  - All other behaviour is identical.

Decomposition:
- Package axi_sdram_pkg holds:
  - AXI_RESP_OKAY=2'b00.
  - The function clog2.
  - The function first-beat-keep-mask(addr_lsb, STRB_WIDTH).
- One sub-module: axi_sdram_bresp_queue, a parametrised sync FIFO (width, depth) with full, empty and level outputs.
  - When the optional feature is off it is instantiated with width 0, which selects the counter-only generate branch.

Test Plan:
- DATA_WIDTH=32, message addr_lsb=2'b10, 4-beat burst with wstrb=4'hF, AXIS always ready -> keep sequence F0: 4'hC, 4'hF, 4'hF, 4'hF; one pop at the last beat; bvalid on the next cycle, resp 2'b00.
- DATA_WIDTH=64, addr_lsb=3'd5, single-beat burst with wstrb=8'hFF -> keep=8'hE0, last=1; first_beat stays 1 for the next burst.
- B_QUEUE_DEPTH=4, bready=0, five single-beat bursts -> four accepted, b_queue_level=4, wready=0 on the fifth; one bready pulse -> fifth accepted one cycle later.
- Feature on, IDs 3, 7, 1 sent back-to-back, bready random -> bid order 3, 7, 1, each held stable while bvalid=1 & bready=0.
- Message FIFO empty_n=0 with wvalid=1 -> wready=0 and wt_valid=0 for 10 cycles; empty_n=1 -> beat passes in the same cycle.
- Reset asserted after beat 2 of a 4-beat burst -> bvalid=0 and level=0 immediately; next burst's first beat is masked.
